// File: rtl/lininterp_core.sv
// Streaming linear interpolator: steps a fractional phase between the two most
// recent input samples and emits a + (b-a)*frac at full precision (scaled by 2^MW).
module lininterp_core #(
  parameter int IW = 16,
  parameter int PW = 24,
  parameter int MW = 8
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [PW-1:0]               i_step,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic signed [IW-1:0]        i_sample,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic signed [IW+MW-1:0]     o_data
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_WAIT, S_RUN} state_t;

  state_t                     state, state_next;
  logic [PW-1:0]              r_phase;
  logic signed [IW-1:0]       r_last, r_next;
  logic                       ce, accept, issue, carry;
  logic [PW-1:0]              phase_sum;

  logic                       v1, v2;
  logic signed [IW:0]         diff1;
  logic signed [IW-1:0]       base1, base2;
  logic [MW-1:0]              frac1;
  logic signed [IW+MW-1:0]    prod, prod2;

  assign ce      = !o_valid || i_ready;
  assign o_ready = (state != S_RUN);
  assign accept  = i_valid && o_ready;
  assign issue   = (state == S_RUN) && ce;
  assign {carry, phase_sum} = {1'b0, r_phase} + {1'b0, i_step};

  // The final sum always fits in IW+MW bits, so the product only needs to be
  // kept modulo 2^(IW+MW); the dropped high bit would be discarded anyway.
  assign prod = (IW+MW)'(diff1) * (IW+MW)'($signed({1'b0, frac1}));

  always_comb begin
    state_next = state;
    case (state)
      S_EMPTY:      if (accept) state_next = S_ONE;
      S_ONE,
      S_WAIT:       if (accept) state_next = S_RUN;
      S_RUN:        if (issue && carry) state_next = S_WAIT;
      default:      state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= S_EMPTY;
    else         state <= state_next;
  end

  // The phase is never cleared on wrap so the residue carries into the next interval.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_phase <= '0;
      r_last  <= '0;
      r_next  <= '0;
    end else begin
      if (accept) begin
        r_next <= i_sample;
        if (state != S_EMPTY) r_last <= r_next;
      end
      if (issue) r_phase <= phase_sum;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      v1      <= 1'b0;
      v2      <= 1'b0;
      diff1   <= '0;
      base1   <= '0;
      base2   <= '0;
      frac1   <= '0;
      prod2   <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (ce) begin
      v1 <= issue;
      if (issue) begin
        diff1 <= {r_next[IW-1], r_next} - {r_last[IW-1], r_last};
        base1 <= r_last;
        frac1 <= r_phase[PW-1 -: MW];
      end
      v2      <= v1;
      prod2   <= prod;
      base2   <= base1;
      o_valid <= v2;
      o_data  <= {base2, {MW{1'b0}}} + prod2;
    end
  end

endmodule

// File: tb/tb_lininterp_core.sv
// Directed bench for lininterp_core: hand-computed interpolation vectors, wrap
// bubbles, backpressure hold, fill/handshake, mid-run reset and zero step.
module tb_lininterp_core;

  localparam int IW = 16;
  localparam int PW = 24;
  localparam int MW = 8;

  logic                     i_clk = 1'b0;
  logic                     i_reset;
  logic [PW-1:0]            i_step;
  logic                     i_valid;
  logic                     o_ready;
  logic signed [IW-1:0]     i_sample;
  logic                     o_valid;
  logic                     i_ready;
  logic signed [IW+MW-1:0]  o_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int outq[$];
  int timeq[$];
  int expq[$];

  lininterp_core #(.IW(IW), .PW(PW), .MW(MW)) dut (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_step  (i_step),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_sample(i_sample),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_data  (o_data)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Record every completed output handshake with the cycle it happened in.
  always @(negedge i_clk) begin
    if (!i_reset && o_valid && i_ready) begin
      outq.push_back(int'(o_data));
      timeq.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic doReset();
    i_reset = 1'b1;
    tick(1);
    i_reset = 1'b0;
    outq.delete();
    timeq.delete();
  endtask

  // Offer one sample and hold it until the block takes it (bounded).
  task automatic applyStimulus(input int s);
    bit done;
    done     = 1'b0;
    i_sample = 16'(s);
    i_valid  = 1'b1;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge i_clk);
      if (o_ready) done = 1'b1;
    end
    if (done) tick(1);
    else checkOutput("accept_timeout", 0, 1);
    i_valid = 1'b0;
  endtask

  task automatic checkQueue(input string tag);
    checkOutput({tag, "_count"}, outq.size(), expq.size());
    for (int i = 0; i < expq.size(); i++) begin
      if (i < outq.size()) checkOutput($sformatf("%s_%0d", tag, i), outq[i], expq[i]);
    end
  endtask

  task automatic checkGaps(input string tag, input int g1, input int g2, input int g3);
    if (timeq.size() >= 4) begin
      checkOutput({tag, "_gap1"}, timeq[1] - timeq[0], g1);
      checkOutput({tag, "_gap2"}, timeq[2] - timeq[1], g2);
      checkOutput({tag, "_gap3"}, timeq[3] - timeq[2], g3);
    end else begin
      checkOutput({tag, "_gap_samples"}, timeq.size(), 4);
    end
  endtask

  initial begin
    i_reset  = 1'b1;
    i_valid  = 1'b0;
    i_sample = '0;
    i_step   = '0;
    i_ready  = 1'b1;
    tick(2);
    i_reset = 1'b0;

    @(negedge i_clk);
    checkOutput("reset_valid", int'(o_valid), 0);
    checkOutput("reset_ready", int'(o_ready), 1);
    checkOutput("reset_data", int'(o_data), 0);
    tick(1);

    // Basic: 0 -> 1024 at step 0.25
    doReset();
    i_step = 24'h400000;
    applyStimulus(0);
    applyStimulus(1024);
    tick(10);
    expq = '{0, 65536, 131072, 196608};
    checkQueue("basic");
    checkGaps("basic", 1, 1, 1);
    @(negedge i_clk);
    checkOutput("basic_wait_ready", int'(o_ready), 1);
    checkOutput("basic_idle_valid", int'(o_valid), 0);
    tick(1);

    // Signed crossing at step 0.5, one bubble at the wrap
    doReset();
    i_step = 24'h800000;
    applyStimulus(-1000);
    applyStimulus(1000);
    applyStimulus(1000);
    tick(10);
    expq = '{-256000, 0, 256000, 256000};
    checkQueue("cross");
    checkGaps("cross", 1, 2, 1);

    // Backpressure: stall while the second output is presented
    doReset();
    i_step = 24'h400000;
    applyStimulus(0);
    applyStimulus(1024);
    tick(4);
    i_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      checkOutput("bp_hold_valid", int'(o_valid), 1);
      checkOutput("bp_hold_data", int'(o_data), 65536);
      tick(1);
    end
    i_ready = 1'b1;
    tick(10);
    expq = '{0, 65536, 131072, 196608};
    checkQueue("bp");

    // Fill and handshake: one sample produces nothing; a held sample waits for the wrap
    doReset();
    i_step = 24'h400000;
    applyStimulus(100);
    for (int i = 0; i < 5; i++) begin
      @(negedge i_clk);
      checkOutput("fill_valid", int'(o_valid), 0);
      checkOutput("fill_ready", int'(o_ready), 1);
      tick(1);
    end
    applyStimulus(200);
    i_sample = 16'sd300;
    i_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge i_clk);
      checkOutput("run_ready", int'(o_ready), 0);
      tick(1);
    end
    @(negedge i_clk);
    checkOutput("wrap_ready", int'(o_ready), 1);
    tick(1);
    i_valid = 1'b0;
    tick(10);
    expq = '{25600, 32000, 38400, 44800, 51200, 57600, 64000, 70400};
    checkQueue("fill");

    // Reset mid-run with the pipeline full and the phase at 0.75
    doReset();
    i_step = 24'h400000;
    applyStimulus(0);
    applyStimulus(1024);
    tick(3);
    @(negedge i_clk);
    checkOutput("prereset_valid", int'(o_valid), 1);
    i_reset = 1'b1;
    tick(1);
    i_reset = 1'b0;
    @(negedge i_clk);
    checkOutput("postreset_valid", int'(o_valid), 0);
    checkOutput("postreset_ready", int'(o_ready), 1);
    tick(1);
    outq.delete();
    timeq.delete();
    applyStimulus(512);
    applyStimulus(1536);
    tick(10);
    expq = '{131072, 196608, 262144, 327680};
    checkQueue("restart");

    // Zero step: the same value repeats and the block never wraps
    doReset();
    i_step = '0;
    applyStimulus(5);
    applyStimulus(9);
    tick(4);
    for (int i = 0; i < 10; i++) begin
      @(negedge i_clk);
      checkOutput("zero_valid", int'(o_valid), 1);
      checkOutput("zero_data", int'(o_data), 1280);
      checkOutput("zero_ready", int'(o_ready), 0);
      tick(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lininterp_core.md
Name: lininterp_core

Overview:
Streaming linear interpolator (upsampler) that sits directly upstream of the rounding stage in the lininterp chain. It accepts input samples on a valid/ready stream and steps a fractional phase accumulator by a programmable step. For each phase it emits the full-precision interpolated value a + (b-a)*frac. The output is IW+MW bits wide and is handed to the rounding stage as its i_data (IWID = IW+MW) for reduction to the final width.

Parameters:
IW, 16, signed input sample width
PW, 24, phase accumulator width; step and phase are unsigned fractions of one input interval (2^PW = 1.0)
MW, 8, fraction bits used in the multiply, taken as phase[PW-1 -: MW]; requires MW <= PW

Ports:
i_clk  input  1  system clock
i_reset  input  1  synchronous reset, active high
i_step  input  PW  phase increment per output; sampled at each issue; may change at any time
i_valid  input  1  input sample valid
o_ready  output  1  block accepts i_sample this cycle
i_sample  input  IW  signed input sample
o_valid  output  1  o_data valid
i_ready  input  1  downstream (rounding stage) accepts o_data
o_data  output  IW+MW  signed interpolated value, scaled by 2^MW

Behaviour:
- One clock, i_clk. Reset is synchronous and active-high on i_reset.
- Reset values: state=S_EMPTY, r_phase=0, r_last=0, r_next=0, all stage valids=0, o_valid=0, o_data=0.
- A reset asserted mid-operation discards all in-flight results and samples. o_valid is low on the cycle after reset.
- Input accept: o_ready = (state != S_RUN). A sample is accepted when i_valid && o_ready.
- States and transitions:
  - S_EMPTY: on accept, r_next <= i_sample; go to S_ONE.
  - S_ONE: on accept, r_last <= r_next and r_next <= i_sample; go to S_RUN.
  - S_WAIT: on accept, same shift as S_ONE; go to S_RUN.
  - S_RUN: issue one output per ce cycle.
- Pipeline enable: ce = !o_valid || i_ready. All pipeline stages, including o_valid and o_data, advance only when ce=1.
- Issue, when state==S_RUN && ce:
  - stage1 captures diff = r_next - r_last (IW+1 bits, sign-extended), base = r_last, frac = r_phase[PW-1 -: MW], and sets v1=1.
  - {carry, r_phase} <= r_phase + i_step. If carry=1, go to S_WAIT; otherwise stay in S_RUN.
- Stage2: prod = diff * {1'b0, frac}, signed, IW+MW+1 bits; base is carried forward with the product.
- Stage3: o_data <= ({base, MW'b0} + prod), truncated to IW+MW bits. The result always lies between a*2^MW and b*2^MW, so the truncation loses nothing. o_valid <= v2.
- Latency: 3 ce-cycles from issue to o_valid.
- Throughput: 1 output/cycle while in S_RUN. Each phase wrap costs at least one cycle while waiting in S_WAIT for the next sample.
- The phase is not reset on wrap. The residue after a carry carries into the next interval, which keeps the long-term ratio exact at 2^PW / step outputs per input.
- Backpressure: while o_valid && !i_ready, o_data, o_valid and all internal stages hold, and no issue or phase update occurs. Input acceptance is still allowed in non-RUN states.
- i_step = 0: the block never wraps and repeats the same interpolated value indefinitely. This is legal.
- Simultaneous events: a wrap on issue and an input-valid in the same cycle are not combined. The sample is accepted on a later cycle, in S_WAIT.
- Samples are never dropped. i_valid held while o_ready=0 is simply not accepted.

Test Plan:
- Basic interpolation: IW=16, PW=24, MW=8, step=0x400000 (0.25), samples 0 then 1024, i_ready=1 -> o_data = 0, 65536, 131072, 196608 on four consecutive cycles, then the block waits for the next sample.
- Signed crossing: step=0x800000 (0.5), samples -1000, 1000, 1000 -> o_data = -256000, 0, 256000, 256000, with exactly one output bubble at each wrap.
- Backpressure: during the basic scenario, drop i_ready for 5 cycles after the second output -> o_data holds 65536 with o_valid=1, and the remaining outputs follow in order with no loss or duplication.
- Fill and handshake: a single sample only -> o_valid stays 0 and o_ready stays 1. Assert i_valid while in S_RUN -> no accept (o_ready=0) until the wrap.
- Reset mid-run: assert i_reset for 1 cycle while outputs are in flight -> o_valid=0 on the next cycle, and o_ready=1 in S_EMPTY. Two new samples restart from phase 0.
- Zero step: step=0, samples 5, 9 -> o_data = 1280 every cycle indefinitely, and o_ready stays 0.
